// File: rtl/oam_dma.sv
// Sprite OAM DMA controller and CPU bus arbiter: halts the CPU and copies a page to OAMDATA.
// Define OAM_DMA_ALIGN_EN to add the ALIGN state so every READ falls on an even parity cycle.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DST_ADDR     = 16'h2004,
  parameter int          LENGTH       = 256
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
`else
  typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] count;
  logic [7:0] data;
  logic       trigger;

  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  // Free-running cycle parity; it keeps toggling whether or not a transfer is in flight.
  logic parity;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      page  <= 8'h00;
      count <= 8'h00;
      data  <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (trigger) begin
            page  <= cpu_dout;
            count <= 8'h00;
          end
        end
        READ: begin
          data <= bus_din;
        end
        WRITE: begin
          if (count != LAST) begin
            count <= count + 8'h01;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outside IDLE the CPU side is ignored except for the address shown during dummy cycles.
  always_comb begin
    state_nxt = state;
    bus_addr  = cpu_addr;
    bus_dout  = cpu_dout;
    bus_we    = cpu_we;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        bus_dout = data;
        bus_we   = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
        state_nxt = parity ? READ : ALIGN;
`else
        state_nxt = READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ALIGN: begin
        bus_dout  = data;
        bus_we    = 1'b0;
        state_nxt = READ;
      end
`endif
      READ: begin
        // The offset replaces the low byte, so the source never carries into the next page.
        bus_addr  = {page, count};
        bus_dout  = data;
        bus_we    = 1'b0;
        state_nxt = WRITE;
      end
      WRITE: begin
        bus_addr  = DST_ADDR;
        bus_dout  = data;
        bus_we    = 1'b1;
        state_nxt = (count == LAST) ? IDLE : READ;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cpu_rdy    = (state == IDLE);
  assign dma_active = ~cpu_rdy;

endmodule
